// File: rtl/ifmap_bank_ring.sv
// N-bank rotating feature-map buffer: DMA load, tensor read, result write and DMA drain,
// with the compute bank advancing on every conv_en so each layer's results feed the next.
module ifmap_bank_ring #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_BANKS  = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  conv_en,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    input  logic                  drain_start,
    input  logic [ADDR_WIDTH:0]   drain_len,
    input  logic [ADDR_WIDTH-1:0] t_addr,
    input  logic                  t_addr_vld,
    output logic [DATA_WIDTH-1:0] t_data,
    output logic                  t_data_vld,
    input  logic [ADDR_WIDTH-1:0] res_addr,
    input  logic [DATA_WIDTH-1:0] res_data,
    input  logic                  res_we,
    output logic [1:0]            cbank,
    output logic                  busy,
    output logic                  err
);
    localparam int                  DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [1:0]          LAST_BANK = 2'(NUM_BANKS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t                state;
    logic                  alive;
    logic [1:0]            rbank;
    logic [ADDR_WIDTH:0]   load_cnt;
    logic [ADDR_WIDTH:0]   drain_addr;
    logic [ADDR_WIDTH:0]   drain_len_q;
    logic                  inflight;
    logic                  inflight_last;
    logic [1:0]            sk_count;
    logic [DATA_WIDTH-1:0] sk_data [2];
    logic                  sk_last [2];
    logic [1:0]            rd_bank;
    logic [DATA_WIDTH-1:0] t_hold;
    logic [DATA_WIDTH-1:0] bank_q [NUM_BANKS];
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  s_fire;
    logic                  m_fire;
    logic                  ld_we;
    logic                  ld_drop;
    logic                  tensor_rd;
    logic                  drain_issue;
    logic                  rd_en;
    logic                  abort;
    logic                  drain_len_ok;
    logic                  drain_err;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [2:0]            pending;

    assign rbank   = (cbank == LAST_BANK) ? 2'd0 : cbank + 2'd1;

    // alive keeps s_ready low while reset is asserted even though the FSM sits in IDLE
    assign s_ready = alive && enable && (state == IDLE || state == LOAD);
    assign s_fire  = s_ready && s_valid;
    assign ld_addr = (state == LOAD) ? load_cnt[ADDR_WIDTH-1:0] : '0;
    assign ld_drop = (state == LOAD) && load_cnt[ADDR_WIDTH];
    assign ld_we   = s_fire && !ld_drop;

    assign m_valid = enable && (sk_count != 2'd0);
    assign m_data  = sk_data[0];
    assign m_last  = m_valid && sk_last[0];
    assign m_fire  = m_valid && m_ready;
    assign abort   = enable && (state == DRAIN) && conv_en;

    // Counting the beat leaving this cycle keeps the drain at one beat per clock
    assign pending     = {1'b0, sk_count} + {2'b00, inflight} - {2'b00, m_fire};
    assign drain_issue = enable && (state == DRAIN) && !conv_en &&
                         (drain_addr < drain_len_q) && (pending < 3'd2);
    assign tensor_rd   = enable && (state == IDLE) && t_addr_vld;
    assign rd_en       = tensor_rd || drain_issue;
    assign rd_addr     = (state == DRAIN) ? drain_addr[ADDR_WIDTH-1:0] : t_addr;

    assign drain_len_ok = (drain_len != '0) && (drain_len <= DEPTH_W);
    assign drain_err    = drain_start && !((state == IDLE) && conv_en) &&
                          ((state != IDLE) || !drain_len_ok || s_valid);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DATA_WIDTH-1:0] q;
        logic                  ld_sel;
        logic                  res_sel;
        logic                  rd_sel;

        assign ld_sel  = ld_we && (cbank == 2'(b));
        assign res_sel = res_we && (rbank == 2'(b));
        assign rd_sel  = rd_en && (cbank == 2'(b));

        always_ff @(posedge clk) begin
            if (ld_sel)
                mem[ld_addr] <= s_data;
            else if (res_sel)
                mem[res_addr] <= res_data;
            if (rd_sel)
                q <= mem[rd_addr];
        end

        assign bank_q[b] = q;
    end

    always_comb begin
        rd_data = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            if (rd_bank == 2'(b))
                rd_data = bank_q[b];
    end

    assign t_data = t_data_vld ? rd_data : t_hold;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            alive         <= 1'b0;
            cbank         <= 2'd0;
            load_cnt      <= '0;
            drain_addr    <= '0;
            drain_len_q   <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            rd_bank       <= 2'd0;
            t_data_vld    <= 1'b0;
            t_hold        <= '0;
            busy          <= 1'b0;
            err           <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (t_data_vld)
                t_hold <= rd_data;
            if (enable) begin
                t_data_vld    <= tensor_rd;
                inflight      <= drain_issue;
                inflight_last <= drain_issue && (drain_addr == drain_len_q - CNT_ONE);
                if (rd_en)
                    rd_bank <= cbank;
                if (drain_issue)
                    drain_addr <= drain_addr + CNT_ONE;
                if ((t_addr_vld && state != IDLE) || drain_err ||
                    (s_fire && ld_drop) || (conv_en && state == LOAD))
                    err <= 1'b1;

                case (state)
                    IDLE: begin
                        if (conv_en)
                            cbank <= rbank;
                        if (s_fire) begin
                            load_cnt <= CNT_ONE;
                            state    <= s_last ? IDLE : LOAD;
                            busy     <= !s_last;
                        end else if (drain_start && drain_len_ok && !conv_en) begin
                            drain_addr  <= '0;
                            drain_len_q <= drain_len;
                            state       <= DRAIN;
                            busy        <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (s_fire) begin
                            if (!load_cnt[ADDR_WIDTH])
                                load_cnt <= load_cnt + CNT_ONE;
                            if (s_last) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    DRAIN: begin
                        if (conv_en) begin
                            cbank <= rbank;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (m_fire && m_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Two-entry skid: entry 0 is the presented beat, entry 1 absorbs a read landing during a stall
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sk_count   <= 2'd0;
            sk_data[0] <= '0;
            sk_data[1] <= '0;
            sk_last[0] <= 1'b0;
            sk_last[1] <= 1'b0;
        end else if (enable) begin
            if (abort) begin
                sk_count <= 2'd0;
            end else begin
                case ({inflight, m_fire})
                    2'b10: begin
                        if (sk_count == 2'd0) begin
                            sk_data[0] <= rd_data;
                            sk_last[0] <= inflight_last;
                        end else begin
                            sk_data[1] <= rd_data;
                            sk_last[1] <= inflight_last;
                        end
                        sk_count <= sk_count + 2'd1;
                    end
                    2'b01: begin
                        sk_data[0] <= sk_data[1];
                        sk_last[0] <= sk_last[1];
                        sk_count   <= sk_count - 2'd1;
                    end
                    2'b11: begin
                        if (sk_count == 2'd1) begin
                            sk_data[0] <= rd_data;
                            sk_last[0] <= inflight_last;
                        end else begin
                            sk_data[0] <= sk_data[1];
                            sk_last[0] <= sk_last[1];
                            sk_data[1] <= rd_data;
                            sk_last[1] <= inflight_last;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ifmap_bank_ring.sv
// Directed self-checking bench for ifmap_bank_ring (3 banks, 1024-word banks).
module tb_ifmap_bank_ring;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NB = 3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          enable = 1'b0;
    logic          conv_en = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic          drain_start = 1'b0;
    logic [AW:0]   drain_len = '0;
    logic [AW-1:0] t_addr = '0;
    logic          t_addr_vld = 1'b0;
    logic [DW-1:0] t_data;
    logic          t_data_vld;
    logic [AW-1:0] res_addr = '0;
    logic [DW-1:0] res_data = '0;
    logic          res_we = 1'b0;
    logic [1:0]    cbank;
    logic          busy;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifmap_bank_ring #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_BANKS (NB)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .conv_en    (conv_en),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .drain_start(drain_start),
        .drain_len  (drain_len),
        .t_addr     (t_addr),
        .t_addr_vld (t_addr_vld),
        .t_data     (t_data),
        .t_data_vld (t_data_vld),
        .res_addr   (res_addr),
        .res_data   (res_data),
        .res_we     (res_we),
        .cbank      (cbank),
        .busy       (busy),
        .err        (err)
    );

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tensorRead(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] expected);
        t_addr     = addr;
        t_addr_vld = 1'b1;
        applyStimulus(1);
        t_addr_vld = 1'b0;
        checkOutput({tag, " t_data"}, t_data, expected);
        checkOutput({tag, " t_data_vld"}, t_data_vld, 1);
    endtask

    task automatic resultThenRotate(input logic [DW-1:0] value, input logic [1:0] next_bank);
        res_addr = 10'd20;
        res_data = value;
        res_we   = 1'b1;
        applyStimulus(1);
        res_we  = 1'b0;
        conv_en = 1'b1;
        applyStimulus(1);
        conv_en = 1'b0;
        checkOutput("rotate cbank", cbank, next_bank);
        tensorRead("rotate result", 10'd20, value);
    endtask

    // Drains 8 words 0x10..0x17; stall uses m_ready pattern 1,0,0; abort_beat>0 fires conv_en on that beat
    task automatic drainAndCheck(input string tag, input bit stall, input int abort_beat);
        int            beats = 0;
        int            first = -1;
        bit            prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        drain_len   = 11'd8;
        drain_start = 1'b1;
        applyStimulus(1);
        drain_start = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            m_ready = stall ? (cyc % 3 == 0) : 1'b1;
            #1;
            if (prev_stall) begin
                checkOutput({tag, " hold valid"}, m_valid, 1);
                checkOutput({tag, " hold data"}, m_data, prev_data);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (m_valid && m_ready) begin
                checkOutput({tag, " data"}, m_data, 32'h10 + 32'(beats));
                checkOutput({tag, " last"}, m_last, (beats == 7));
                if (!stall) begin
                    if (first < 0) first = cyc;
                    checkOutput({tag, " spacing"}, 64'(cyc - first), 64'(beats));
                end
                beats++;
                if (beats == abort_beat) begin
                    conv_en = 1'b1;
                    applyStimulus(1);
                    conv_en = 1'b0;
                    break;
                end
            end
            applyStimulus(1);
        end
        m_ready = 1'b0;
        if (abort_beat > 0) begin
            checkOutput({tag, " beats"}, 64'(beats), 64'(abort_beat));
            checkOutput({tag, " m_valid"}, m_valid, 0);
            checkOutput({tag, " m_last"}, m_last, 0);
            checkOutput({tag, " busy"}, busy, 0);
            applyStimulus(3);
            checkOutput({tag, " m_valid later"}, m_valid, 0);
        end else begin
            checkOutput({tag, " beats"}, 64'(beats), 8);
            checkOutput({tag, " busy"}, busy, 0);
            checkOutput({tag, " m_valid idle"}, m_valid, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values with enable high
        enable = 1'b1;
        applyStimulus(2);
        checkOutput("reset s_ready", s_ready, 0);
        checkOutput("reset m_valid", m_valid, 0);
        checkOutput("reset m_last", m_last, 0);
        checkOutput("reset m_data", m_data, 0);
        checkOutput("reset t_data", t_data, 0);
        checkOutput("reset t_data_vld", t_data_vld, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset cbank", cbank, 0);

        rstn = 1'b1;
        applyStimulus(1);
        checkOutput("idle s_ready", s_ready, 1);

        // enable low stalls the load handshake and tensor reads
        enable     = 1'b0;
        t_addr_vld = 1'b1;
        #1;
        checkOutput("disabled s_ready", s_ready, 0);
        applyStimulus(1);
        checkOutput("disabled t_data_vld", t_data_vld, 0);
        t_addr_vld = 1'b0;
        enable     = 1'b1;

        // Load 0x10..0x17 into compute bank 0
        for (int k = 0; k < 8; k++) begin
            s_valid = 1'b1;
            s_data  = 32'h10 + 32'(k);
            s_last  = (k == 7);
            applyStimulus(1);
            if (k == 3) checkOutput("load busy", busy, 1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        checkOutput("load done busy", busy, 0);

        tensorRead("read addr3", 10'd3, 32'h13);
        applyStimulus(1);
        checkOutput("read idle vld", t_data_vld, 0);
        checkOutput("read held data", t_data, 32'h13);
        tensorRead("read addr7", 10'd7, 32'h17);

        drainAndCheck("drain", 1'b0, 0);
        drainAndCheck("stall", 1'b1, 0);

        // Results land in the result bank and become readable after rotation
        resultThenRotate(32'hA5, 2'd1);
        resultThenRotate(32'hB6, 2'd2);
        resultThenRotate(32'hC7, 2'd0);
        tensorRead("bank0 kept", 10'd3, 32'h13);
        checkOutput("no err yet", err, 0);

        drainAndCheck("abort", 1'b0, 4);
        checkOutput("abort cbank", cbank, 1);

        // Zero-length drain is rejected and the error is sticky until reset
        drain_len   = 11'd0;
        drain_start = 1'b1;
        applyStimulus(1);
        drain_start = 1'b0;
        checkOutput("len0 err", err, 1);
        checkOutput("len0 busy", busy, 0);
        applyStimulus(3);
        checkOutput("len0 err sticky", err, 1);
        rstn = 1'b0;
        #1;
        checkOutput("async reset err", err, 0);
        checkOutput("async reset cbank", cbank, 0);
        applyStimulus(1);
        rstn = 1'b1;
        applyStimulus(1);

        // 1025 beats: the last one overflows the bank
        for (int k = 0; k < 1025; k++) begin
            s_valid = 1'b1;
            s_data  = 32'(k);
            s_last  = (k == 1024);
            applyStimulus(1);
            if (k == 1023) checkOutput("full bank err", err, 0);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        checkOutput("overflow err", err, 1);
        checkOutput("overflow busy", busy, 0);
        tensorRead("read addr1023", 10'd1023, 32'd1023);
        rstn = 1'b0;
        #1;
        checkOutput("final reset err", err, 0);
        rstn = 1'b1;
        applyStimulus(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
